// File: rtl/hilbert_mac_sequencer.sv
// Control sequencer for a single-MAC Hilbert FIR: sample write, tap stepping, accumulator strobes.
// Optional macro HILBERT_SKIP_ZERO_TAPS_EN visits only nonzero (odd-offset) taps plus a centre capture slot.
module hilbert_mac_sequencer #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned TAPS    = 15,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned MAC_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [WIDTH-1:0]  ram_wdata,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] coef_idx,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              re_capture,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);
    localparam int unsigned KW = ADDR_W + 1;
    localparam int unsigned C  = (TAPS - 1) / 2;
    localparam int unsigned DW = $clog2(MAC_LAT + 2);
`ifdef HILBERT_SKIP_ZERO_TAPS_EN
    localparam int unsigned K_FIRST = (C % 2 == 1) ? 0 : 1;
`else
    localparam int unsigned K_FIRST = 0;
`endif

    typedef enum logic [2:0] {CLEAR, IDLE, MAC, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] k;
    logic [DW-1:0]     drain_cnt;
    logic [KW-1:0]     k_next;
    logic [KW-1:0]     rd_addr;
    logic              k_last;
    logic              s_clr;
    logic              s_en;
    logic              s_cap;
    logic              in_mac;

    assign in_mac = (state == MAC);

    // Next visited tap; skip mode steps over zero coefficients but still stops once at the centre
    always_comb begin
`ifdef HILBERT_SKIP_ZERO_TAPS_EN
        if (k == ADDR_W'(C - 1) || k == ADDR_W'(C)) begin
            k_next = KW'(k) + KW'(1);
        end else begin
            k_next = KW'(k) + KW'(2);
        end
        s_en = in_mac && (k != ADDR_W'(C));
`else
        k_next = KW'(k) + KW'(1);
        s_en   = in_mac;
`endif
        k_last = (k_next >= KW'(TAPS));
        s_clr  = in_mac && (k == ADDR_W'(K_FIRST));
        s_cap  = in_mac && (k == ADDR_W'(C));
        if (head >= k) begin
            rd_addr = KW'(head) - KW'(k);
        end else begin
            rd_addr = KW'(head) + KW'(TAPS) - KW'(k);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            wr_ptr    <= '0;
            head      <= '0;
            k         <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == ADDR_W'(TAPS - 1)) begin
                        clr_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        head   <= wr_ptr;
                        wr_ptr <= (wr_ptr == ADDR_W'(TAPS - 1)) ? '0 : wr_ptr + ADDR_W'(1);
                        k      <= ADDR_W'(K_FIRST);
                        state  <= MAC;
                    end
                end
                MAC: begin
                    if (k_last) begin
                        k         <= '0;
                        drain_cnt <= '0;
                        state     <= (MAC_LAT == 0) ? DONE : DRAIN;
                    end else begin
                        k <= k_next[ADDR_W-1:0];
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(MAC_LAT - 1)) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Strobes are aligned to the accumulator add stage MAC_LAT cycles after the read address
    generate
        if (MAC_LAT == 0) begin : g_nopipe
            assign acc_clr    = s_clr;
            assign acc_en     = s_en;
            assign re_capture = s_cap;
        end else begin : g_pipe
            logic [2:0] pipe [MAC_LAT];
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < int'(MAC_LAT); i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= {s_clr, s_en, s_cap};
                    for (int i = 1; i < int'(MAC_LAT); i++) pipe[i] <= pipe[i-1];
                end
            end
            assign {acc_clr, acc_en, re_capture} = pipe[MAC_LAT-1];
        end
    endgenerate

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_ptr;
        ram_wdata = in_data;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = '0;
        end else if (state == IDLE) begin
            ram_we = in_valid;
        end
    end

    assign ram_raddr = in_mac ? rd_addr[ADDR_W-1:0] : '0;
    assign coef_idx  = in_mac ? k : '0;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_hilbert_mac_sequencer.sv
// Directed self-checking bench for hilbert_mac_sequencer (TAPS=15, MAC_LAT=2).
// Expectations follow HILBERT_SKIP_ZERO_TAPS_EN when it is defined.
module tb_hilbert_mac_sequencer;
    localparam int TAPS = 15;
    localparam int MLAT = 2;
`ifdef HILBERT_SKIP_ZERO_TAPS_EN
    localparam int ML = 9;
    int coef_tab [ML] = '{0, 2, 4, 6, 7, 8, 10, 12, 14};
    int en_tab   [ML] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
`else
    localparam int ML = 15;
    int coef_tab [ML] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    int en_tab   [ML] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    localparam int LAT = ML + MLAT + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = 12'h000;
    logic        ram_we;
    logic [3:0]  ram_waddr;
    logic [11:0] ram_wdata;
    logic [3:0]  ram_raddr;
    logic [3:0]  coef_idx;
    logic        acc_clr;
    logic        acc_en;
    logic        re_capture;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    hilbert_mac_sequencer dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .coef_idx(coef_idx), .acc_clr(acc_clr), .acc_en(acc_en),
        .re_capture(re_capture), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'(0));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_acc_clr"}, 32'(acc_clr), 32'(0));
        check({tag, "_acc_en"}, 32'(acc_en), 32'(0));
        check({tag, "_re_capture"}, 32'(re_capture), 32'(0));
        check({tag, "_raddr"}, 32'(ram_raddr), 32'(0));
        check({tag, "_coef"}, 32'(coef_idx), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(1));
    endtask

    task automatic check_clear(input string tag);
        for (int i = 0; i < TAPS; i++) begin
            check({tag, "_we"}, 32'(ram_we), 32'(1));
            check({tag, "_waddr"}, 32'(ram_waddr), 32'(i));
            check({tag, "_wdata"}, 32'(ram_wdata), 32'(0));
            check({tag, "_in_ready"}, 32'(in_ready), 32'(0));
            check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
            @(negedge clock);
        end
    endtask

    // Called on an IDLE cycle with out_ready=1; returns on the IDLE cycle after the result transfer
    task automatic do_sample(input logic [11:0] d, input int h);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        check("smp_in_ready", 32'(in_ready), 32'(1));
        check("smp_we", 32'(ram_we), 32'(1));
        check("smp_waddr", 32'(ram_waddr), 32'(h));
        check("smp_wdata", 32'(ram_wdata), 32'(d));
        n = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            n++;
            in_valid = 1'b0;
            check("smp_coef", 32'(coef_idx), 32'(coef_tab[j]));
            check("smp_raddr", 32'(ram_raddr), 32'((h - coef_tab[j] + TAPS) % TAPS));
        end
        while (!out_valid && n < 60) begin
            @(negedge clock);
            n++;
        end
        check("smp_latency", 32'(n), 32'(LAT));
        check("smp_done_in_ready", 32'(in_ready), 32'(0));
        @(negedge clock);
        check("smp_busy_between", 32'(busy), 32'(0));
        check("smp_idle_ready", 32'(in_ready), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        #1;
        check_reset_outputs("rst");

        // Clear sweep with in_valid already high: it must be ignored
        in_valid = 1'b1;
        in_data  = 12'h800;
        reset    = 1'b0;
        #1;
        check_clear("clr");

        // First accept in IDLE
        check("idle_in_ready", 32'(in_ready), 32'(1));
        check("idle_we", 32'(ram_we), 32'(1));
        check("idle_waddr", 32'(ram_waddr), 32'(0));
        check("idle_wdata", 32'(ram_wdata), 32'(12'h800));
        check("idle_busy", 32'(busy), 32'(0));

        // in_valid stays high during MAC/DRAIN and must not write
        for (int s = 0; s < ML + MLAT; s++) begin
            @(negedge clock);
            if (s < ML) begin
                check("mac_coef", 32'(coef_idx), 32'(coef_tab[s]));
                check("mac_raddr", 32'(ram_raddr), 32'((TAPS - coef_tab[s]) % TAPS));
            end else begin
                check("drain_coef", 32'(coef_idx), 32'(0));
                check("drain_raddr", 32'(ram_raddr), 32'(0));
            end
            check("mac_acc_clr", 32'(acc_clr), 32'(s == 2));
            if (s >= 2) begin
                check("mac_acc_en", 32'(acc_en), 32'(en_tab[s-2]));
                check("mac_re_capture", 32'(re_capture), 32'(coef_tab[s-2] == 7));
            end else begin
                check("mac_acc_en", 32'(acc_en), 32'(0));
                check("mac_re_capture", 32'(re_capture), 32'(0));
            end
            check("mac_we", 32'(ram_we), 32'(0));
            check("mac_in_ready", 32'(in_ready), 32'(0));
            check("mac_out_valid", 32'(out_valid), 32'(0));
        end

        // Result held while out_ready is low
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("hold_out_valid", 32'(out_valid), 32'(1));
            check("hold_in_ready", 32'(in_ready), 32'(0));
            check("hold_we", 32'(ram_we), 32'(0));
            check("hold_acc_en", 32'(acc_en), 32'(0));
        end
        out_ready = 1'b1;
        in_data   = 12'h123;
        @(negedge clock);
        check("xfer_out_valid", 32'(out_valid), 32'(0));
        do_sample(12'h123, 1);

        // Sixteen back-to-back samples; head wraps from 14 to 0
        for (int i = 0; i < 16; i++) begin
            do_sample(12'(12'h100 + i), (2 + i) % TAPS);
        end

        // Reset in the middle of MAC
        in_valid = 1'b1;
        in_data  = 12'h7FF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
        check("abort_coef", 32'(coef_idx), 32'(coef_tab[5]));
        check("abort_acc_en", 32'(acc_en), 32'(en_tab[3]));
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clock);
        in_valid = 1'b1;
        reset    = 1'b0;
        #1;
        check_clear("reclr");
        check("reclr_in_ready", 32'(in_ready), 32'(1));
        check("reclr_waddr", 32'(ram_waddr), 32'(0));
        in_valid = 1'b0;
        @(negedge clock);
        check("final_busy", 32'(busy), 32'(0));
        check("final_out_valid", 32'(out_valid), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hilbert_mac_sequencer.md
Name: hilbert_mac_sequencer

Overview:
Control sequencer for a time-multiplexed (single-MAC) Hilbert FIR datapath. Accepts one sample per transaction over a valid/ready handshake and writes it into an external circular sample RAM. Steps through all taps, driving RAM read address, coefficient index and accumulator strobes, then presents a result-valid handshake. The Im output is the accumulator; Re is the centre-tap sample, captured on re_capture.

Parameters:
WIDTH, 12, sample width in bits
TAPS, 15, filter length; must be odd and ≥3; centre index C=(TAPS-1)/2
ADDR_W, 4, RAM/coefficient address width; must satisfy 2^ADDR_W ≥ TAPS
MAC_LAT, 2, datapath latency in cycles from ram_raddr/coef_idx to the accumulator add stage

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  sequencer can accept a sample
in_data  in  WIDTH  input sample
ram_we  out  1  sample RAM write enable
ram_waddr  out  ADDR_W  sample RAM write address
ram_wdata  out  WIDTH  sample RAM write data
ram_raddr  out  ADDR_W  sample RAM read address
coef_idx  out  ADDR_W  coefficient ROM index
acc_clr  out  1  load accumulator with product (first tap), MAC_LAT-aligned
acc_en  out  1  accumulate product, MAC_LAT-aligned
re_capture  out  1  latch current RAM read data as Re, MAC_LAT-aligned
out_valid  out  1  Re/Im result valid
out_ready  in  1  consumer accepts result
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=CLEAR, clr_cnt=0, wr_ptr=0, head=0, k=0, strobe pipe zeroed; in_ready=0, out_valid=0, acc_clr=acc_en=re_capture=0, ram_raddr=coef_idx=0.
- States: CLEAR → IDLE → MAC → DRAIN → DONE → IDLE.
- CLEAR: ram_we=1, ram_waddr=clr_cnt, ram_wdata=0; clr_cnt counts 0..TAPS-1, then IDLE. Always entered after reset; in_valid ignored.
- IDLE: in_ready=1. ram_we=in_valid (combinational), ram_waddr=wr_ptr, ram_wdata=in_data. On accept edge: head←wr_ptr, wr_ptr←(wr_ptr+1) mod TAPS (TAPS-1 wraps to 0), k←0, go to MAC.
- MAC: one tap per cycle. ram_raddr=(head−k) mod TAPS, coef_idx=k. Undelayed strobes: clr=(k==first visited k), en=1, cap=(k==C). After the last k, go to DRAIN.
- acc_clr/acc_en/re_capture are the undelayed strobes passed through a MAC_LAT-stage register pipe; they are 0 in all non-MAC source cycles. With MAC_LAT=0 they are combinational from MAC.
- DRAIN: MAC_LAT cycles (0 → skipped), flushing the pipe, then DONE.
- DONE: out_valid=1, held until out_ready=1; transfer edge → IDLE. in_ready=0 in DONE.
- Latency (feature off): accept in cycle A; MAC cycles A+1..A+TAPS; out_valid first high in cycle A+TAPS+MAC_LAT+1 (default 18).
- Throughput: one sample per TAPS+MAC_LAT+2 cycles minimum.
- in_valid outside IDLE: ignored, no write. out_ready without out_valid: ignored.
- Reset mid-operation: immediate return to reset values. Any in-flight result is discarded. CLEAR re-zeroes the history.

Optional Feature:
Macro HILBERT_SKIP_ZERO_TAPS_EN.
- Defined: MAC visits only k with (k−C) odd (Hilbert even-offset coefficients are zero), in ascending order. It also inserts one cycle at k=C with en=0 and cap=1. clr is asserted on the first visited k. MAC length = count of such k + 1 (9 for TAPS=15).
- Undefined: all TAPS taps visited, as above.

Test Plan:
1. Release reset, in_valid=1 → ram_we high 15 cycles, waddr 0..14, wdata 0, in_ready=0; in_ready=1 in cycle 16; nothing written during CLEAR.
2. Accept 0x800 in IDLE → write addr 0. raddr 0,14,13,…,1 with coef_idx 0..14. acc_clr 2 cycles after first read. re_capture 2 cycles after raddr=8. out_valid 18 cycles after accept.
3. Accept 16 samples with out_ready=1 → 16th written at addr 0 (wrap); its read sequence starts 0,14,… and busy deasserts between samples.
4. Hold out_ready=0 for 5 cycles with in_valid=1 → out_valid stays 1, in_ready 0, no ram_we. out_ready=1 → IDLE next cycle; sample accepted there.
5. Assert reset at MAC k=5 → all outputs at reset values without a clock edge. After release, CLEAR replays 15 zero writes. The aborted result never raises out_valid.
6. HILBERT_SKIP_ZERO_TAPS_EN, accept at head=0 → coef_idx 0,2,4,6,7,8,10,12,14. acc_en low only for the 7 slot. re_capture on the 7 slot (delayed 2). out_valid at accept+12.
